// File: rtl/control_transmision_serial_if.sv
`default_nettype none
// ============================================================================
// Module  : control_transmision_serial_if
// Brief   : Request/shift-register control bundle for control_transmision_serial.
// Revision: 1.0 - initial release
// ============================================================================
interface control_transmision_serial_if #(
  parameter int ANCHO = 4
);
  logic             req;
  logic             dir_req;
  logic [ANCHO-1:0] dato;
  logic             cancelar;
  logic             ready;
  logic [1:0]       modo;
  logic             dir;
  logic [ANCHO-1:0] d_par;
  logic             bit_valid;
  logic             done;

  modport master (
    output req, dir_req, dato, cancelar,
    input  ready, modo, dir, d_par, bit_valid, done
  );

  modport slave (
    input  req, dir_req, dato, cancelar,
    output ready, modo, dir, d_par, bit_valid, done
  );
endinterface
`default_nettype wire

// File: rtl/control_transmision_serial.sv
`default_nettype none
// ============================================================================
// Module  : control_transmision_serial
// Brief   : Sequences load/shift/hold of a serial shift register per transfer.
// Revision: 1.0 - initial release
// ============================================================================
module control_transmision_serial #(
  parameter int ANCHO = 4
) (
  input  logic                         clk,
  input  logic                         reset_L,
  control_transmision_serial_if.slave  bus
);

  localparam int               c_cnt_w      = (ANCHO > 1) ? $clog2(ANCHO) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ANCHO - 1);
  localparam logic [1:0]       c_modo_shift = 2'b00;
  localparam logic [1:0]       c_modo_load  = 2'b01;
  localparam logic [1:0]       c_modo_hold  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CARGA = 2'b01,
    DESPL = 2'b10,
    FIN   = 2'b11
  } state_t;

  state_t               r_state,     w_state_next;
  logic [c_cnt_w-1:0]   r_cnt,       w_cnt_next;
  logic [1:0]           r_modo,      w_modo_next;
  logic                 r_ready,     w_ready_next;
  logic                 r_dir,       w_dir_next;
  logic [ANCHO-1:0]     r_d_par,     w_d_par_next;
  logic                 r_bit_valid, w_bit_valid_next;
  logic                 r_done,      w_done_next;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_modo      <= c_modo_hold;
      r_ready     <= 1'b1;
      r_dir       <= 1'b0;
      r_d_par     <= '0;
      r_bit_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_modo      <= w_modo_next;
      r_ready     <= w_ready_next;
      r_dir       <= w_dir_next;
      r_d_par     <= w_d_par_next;
      r_bit_valid <= w_bit_valid_next;
      r_done      <= w_done_next;
    end
  end

  always_comb begin
    w_state_next     = IDLE;
    w_cnt_next       = '0;
    w_dir_next       = r_dir;
    w_d_par_next     = r_d_par;
    w_modo_next      = c_modo_hold;
    w_ready_next     = 1'b0;
    w_bit_valid_next = 1'b0;
    w_done_next      = 1'b0;

    // Abort wins over every other transition; FIN and illegal codes fall to IDLE.
    case (r_state)
      IDLE: begin
        if (bus.req && r_ready && !bus.cancelar) begin
          w_state_next = CARGA;
          w_dir_next   = bus.dir_req;
          w_d_par_next = bus.dato;
        end
      end
      CARGA: begin
        if (!bus.cancelar) w_state_next = DESPL;
      end
      DESPL: begin
        if (!bus.cancelar) begin
          if (r_cnt == c_cnt_last) begin
            w_state_next = FIN;
          end else begin
            w_state_next = DESPL;
            w_cnt_next   = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (w_state_next)
      IDLE:  w_ready_next = 1'b1;
      CARGA: w_modo_next  = c_modo_load;
      DESPL: begin
        w_modo_next      = c_modo_shift;
        w_bit_valid_next = 1'b1;
      end
      FIN:   w_done_next  = 1'b1;
      default: w_ready_next = 1'b1;
    endcase
  end

  assign bus.ready     = r_ready;
  assign bus.modo      = r_modo;
  assign bus.dir       = r_dir;
  assign bus.d_par     = r_d_par;
  assign bus.bit_valid = r_bit_valid;
  assign bus.done      = r_done;

endmodule
`default_nettype wire
